// File: rtl/lcd_bus_arbiter.sv
// Two-port round-robin arbiter for a character-LCD write bus. Each granted write
// is sequenced through setup, enable pulse, hold and a post-write wait.
module lcd_bus_arbiter #(
  parameter int T_PWRUP = 20,
  parameter int T_SETUP = 1,
  parameter int T_EN    = 2,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 2,
  parameter int T_CLR   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic       grant_id,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int CW = $clog2(T_PWRUP + T_SETUP + T_EN + T_HOLD + T_GAP + T_CLR + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          e_q, e_d;
  logic          rw_q, rw_d;
  logic          sel, accept, is_clr;

  // Contention goes to the port that did not own the most recent transfer.
  assign sel    = (req0_valid & req1_valid) ? ~grant_q : req1_valid;
  assign accept = (state_q == S_IDLE) & rst & (req0_valid | req1_valid);
  assign is_clr = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);

  assign req0_ready = accept & ~sel;
  assign req1_ready = accept & sel;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign LCD_E      = e_q;
  assign LCD_RW     = rw_q;
  assign LCD_RS     = rs_q;
  assign LCD_DATA   = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rs_d    = rs_q;
    data_d  = data_q;
    case (state_q)
      S_PWRUP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_IDLE: begin
        if (accept) begin
          grant_d = sel;
          rs_d    = sel ? req1_rs   : req0_rs;
          data_d  = sel ? req1_data : req0_data;
          state_d = S_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_ENABLE;
          cnt_d   = CW'(T_EN - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_ENABLE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = is_clr ? CW'(T_CLR - 1) : CW'(T_GAP - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_PWRUP;
    endcase
    // Pin levels are registered from the next state so E never glitches.
    e_d  = (state_d == S_ENABLE);
    rw_d = !(state_d inside {S_SETUP, S_ENABLE, S_HOLD});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_PWRUP;
      cnt_q   <= CW'(T_PWRUP - 1);
      grant_q <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
      rw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
      rw_q    <= rw_d;
    end
  end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single character-LCD write bus (E/RS/RW/DATA) between two requesters, e.g. the init/status writer (port 0) and the text-line writer (port 1).
- Each requester presents one LCD write at a time over a valid/ready handshake.
- The block arbitrates round-robin, then sequences each write through setup, enable pulse, hold and post-write wait phases, using parameterised cycle counts.
- Sits between the game-side LCD content generators and the LCD pins; it alone drives the LCD pins.

Parameters:
T_PWRUP, 20, cycles after reset before any request is accepted (≥1)
T_SETUP, 1, cycles RS/DATA are stable with E low before E rises (≥1)
T_EN, 2, cycles E is held high (≥1)
T_HOLD, 1, cycles RS/DATA are held with E low after E falls (≥1)
T_GAP, 2, post-write wait for normal commands/data (≥1)
T_CLR, 5, post-write wait for clear/home commands (≥1)

Ports:
clk  in  1  system clock (1 kHz in the LCD domain)
rst  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 has a write pending
req0_rs  in  1  requester 0 register select (0 = command, 1 = data)
req0_data  in  8  requester 0 byte
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid  in  1  requester 1 has a write pending
req1_rs  in  1  requester 1 register select
req1_data  in  8  requester 1 byte
req1_ready  out  1  requester 1 write accepted this cycle
busy  out  1  1 whenever the FSM is not in IDLE
grant_id  out  1  requester owning the current or most recent transfer
LCD_E  out  1  LCD enable
LCD_RS  out  1  LCD register select
LCD_RW  out  1  LCD read/write (0 = write)
LCD_DATA  out  8  LCD data bus

Behaviour:

Reset and interface rules:
- Reset is sampled on the clk rising edge while rst == 0.
- Reset values: state = PWRUP; counter = T_PWRUP-1; LCD_E = 0, LCD_RS = 0, LCD_RW = 1, LCD_DATA = 0x00; busy = 1; grant_id = 1 (so port 0 wins the first contention); both ready outputs = 0.
- Reset asserted in any state aborts the transfer in progress: LCD_E = 0 on the next edge, and no ready pulse is issued.
- Handshake: a requester holds valid, rs and data stable until it sees ready. Ready is combinational, asserted only in IDLE, to at most one port. A transfer occurs on the edge where valid & ready.
- Arbitration in IDLE:
  - If only one port is valid, that port is granted.
  - If both are valid, the port != grant_id is granted.
  - grant_id updates on the acceptance edge.
- On acceptance, rs and data are latched into internal registers. The latched values, not the live inputs, drive LCD_RS and LCD_DATA through the whole transfer.

FSM (a single down-counter is loaded with N-1 on entry to each timed state; the state exits when the counter reaches 0):
- PWRUP: outputs at reset values. After T_PWRUP cycles → IDLE.
- IDLE: LCD_E = 0, LCD_RW = 1, LCD_RS/LCD_DATA hold the last values, busy = 0. Acceptance → SETUP.
- SETUP (T_SETUP cycles): LCD_RW = 0, RS/DATA = latched values, LCD_E = 0 → ENABLE.
- ENABLE (T_EN cycles): LCD_E = 1 → HOLD.
- HOLD (T_HOLD cycles): LCD_E = 0, RS/DATA/RW unchanged → WAIT.
- WAIT: LCD_RW = 1, LCD_E = 0.
  - Lasts T_CLR cycles if the latched rs = 0 and data[7:2] = 0 and data[1:0] != 0 (clear/home commands).
  - Otherwise lasts T_GAP cycles.
  - Then → IDLE.

Timing and boundary conditions:
- LCD_E rises exactly T_SETUP cycles after the acceptance edge.
- A requester's next write can be accepted at the earliest T_SETUP+T_EN+T_HOLD+wait cycles after the previous acceptance.
- Back-to-back requests from a single valid port are all granted to that port; there is no idle slot inserted for fairness.
- A valid that drops while not ready is permitted. Nothing is latched and no transfer is recorded.
- Ready outputs are 0 in every state other than IDLE, including PWRUP.
- Registered outputs change only on clk edges; LCD_E is glitch-free (registered).

Test Plan:
1. Power-up: rst low 3 cycles, then high; req0_valid = 1 from cycle 0. Required: req0_ready = 0 and busy = 1 for exactly 20 cycles after reset release; req0_ready = 1 on cycle 20.
2. Single data write (defaults), req1 rs = 1 data = 0x41. Required:
   - LCD_RW = 0, LCD_RS = 1, LCD_DATA = 0x41 from acceptance+1 through HOLD.
   - LCD_E = 1 for exactly 2 cycles starting at acceptance+1.
   - busy falls 6 cycles after acceptance (1+2+1+2).
3. Clear vs. set-address, req0 rs = 0:
   - data = 0x01 → WAIT lasts 5 cycles (busy high 9 cycles).
   - data = 0x80 → WAIT lasts 2 cycles (busy high 6 cycles).
   - data = 0x02 → 5-cycle WAIT.
4. Contention: both valid continuously with distinct data. Required: grant sequence 0,1,0,1 with grant_id matching; first grant after reset goes to port 0; LCD_DATA alternates between the two requesters' bytes.
5. Reset mid-ENABLE: drive rst low while LCD_E = 1. Required: next edge LCD_E = 0, LCD_RW = 1, LCD_DATA = 0x00, state PWRUP; no ready pulse; a pending request is re-accepted only after T_PWRUP.
6. Input change after acceptance: change req1_data 0x41→0x42 during ENABLE. Required: LCD_DATA stays 0x41 until the transfer completes.
